// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, colour/coordinate types and a span helper
// used by the timing generator and the screen renderers.
package vga_timing_pkg;

  localparam int CNT_W   = 11;
  localparam int COLOR_W = 5;
  localparam int CLK_DIV = 4;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int SCREEN_WIDTH  = H_DISPLAY;
  localparam int SCREEN_HEIGHT = V_DISPLAY;

  typedef logic [CNT_W-1:0]   coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t COLOR_BLACK = '0;

  // Inclusive unsigned range test at coordinate width.
  function automatic logic in_span(coord_t v, int first, int last);
    return (v >= coord_t'(first)) && (v <= coord_t'(last));
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Divides the system clock down to the pixel rate: one-clk p_tick every CLK_DIV clocks,
// first pulse CLK_DIV edges after reset release.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == CW'(CLK_DIV - 1));
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, registered syncs and frame_start,
// plus a registered, blanked colour output for the DAC.
module vga_timing_gen #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [vga_timing_pkg::COLOR_W-1:0]  rgb_in,
  output logic                                p_tick,
  output logic [vga_timing_pkg::CNT_W-1:0]    pixel_x,
  output logic [vga_timing_pkg::CNT_W-1:0]    pixel_y,
  output logic                                video_on,
  output logic                                hsync,
  output logic                                vsync,
  output logic                                frame_start,
  output logic [vga_timing_pkg::COLOR_W-1:0]  rgb_out
);

  import vga_timing_pkg::*;

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_DISPLAY + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_DISPLAY + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  coord_t x_q, x_d, y_q, y_d;
  logic   hsync_q, vsync_q, frame_q;
  color_t rgb_q;
  logic   tick;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == coord_t'(H_TOT - 1)) begin
        x_d = '0;
        y_d = (y_q == coord_t'(V_TOT - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  assign video_on = (x_q < coord_t'(H_DISPLAY)) && (y_q < coord_t'(V_DISPLAY));

  // Syncs and frame_start decode the next counts so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
      rgb_q   <= COLOR_BLACK;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= ~in_span(x_d, HS_FIRST, HS_LAST);
      vsync_q <= ~in_span(y_d, VS_FIRST, VS_LAST);
      frame_q <= tick && (x_d == '0) && (y_d == '0);
      rgb_q   <= video_on ? rgb_in : COLOR_BLACK;
    end
  end

  assign p_tick      = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, CLK_DIV=2, CLK_DIV=2 with a tiny
// geometry so whole frames fit) checked each clk against a closed-form position model.
module tb_vga_timing_gen;

  typedef struct { int d; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb; } geom_t;
  typedef struct { bit pt; int x; int y; bit von; bit hs; bit vs; bit fs; } exp_t;

  // {p_tick, x, y, video_on, hsync, vsync, frame_start, rgb}
  localparam logic [31:0] RESET_VEC = {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [4:0]  rgb_in;
  logic        ptk [3];
  logic        von [3];
  logic        hs  [3];
  logic        vs  [3];
  logic        fs  [3];
  logic [10:0] px  [3];
  logic [10:0] py  [3];
  logic [4:0]  rgbo[3];

  geom_t      g  [3];
  int         k  [3];
  logic [4:0] erg[3];
  int n_pass   = 0;
  int n_checks = 0;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst[0]), .rgb_in(rgb_in), .p_tick(ptk[0]), .pixel_x(px[0]),
    .pixel_y(py[0]), .video_on(von[0]), .hsync(hs[0]), .vsync(vs[0]),
    .frame_start(fs[0]), .rgb_out(rgbo[0]));

  vga_timing_gen #(.CLK_DIV(2)) dut_b (
    .clk(clk), .reset(rst[1]), .rgb_in(rgb_in), .p_tick(ptk[1]), .pixel_x(px[1]),
    .pixel_y(py[1]), .video_on(von[1]), .hsync(hs[1]), .vsync(vs[1]),
    .frame_start(fs[1]), .rgb_out(rgbo[1]));

  vga_timing_gen #(.CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                   .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_c (
    .clk(clk), .reset(rst[2]), .rgb_in(rgb_in), .p_tick(ptk[2]), .pixel_x(px[2]),
    .pixel_y(py[2]), .video_on(von[2]), .hsync(hs[2]), .vsync(vs[2]),
    .frame_start(fs[2]), .rgb_out(rgbo[2]));

  // k = rising edges since the last edge that sampled reset high (0 = in reset).
  function automatic exp_t model(geom_t gm, int kk);
    exp_t e;
    int ht, vt, n, pos;
    ht = gm.hd + gm.hf + gm.hs + gm.hb;
    vt = gm.vd + gm.vf + gm.vs + gm.vb;
    e.pt = 1'b0; e.x = 0; e.y = 0; e.fs = 1'b0;
    if (kk > 0) begin
      n    = (kk - 1) / gm.d;
      pos  = n % (ht * vt);
      e.x  = pos % ht;
      e.y  = pos / ht;
      e.pt = (kk % gm.d) == 0;
      e.fs = (kk > 1) && ((kk - 1) % gm.d == 0) && (pos == 0);
    end
    e.von = (e.x < gm.hd) && (e.y < gm.vd);
    e.hs  = !((e.x >= gm.hd + gm.hf) && (e.x < gm.hd + gm.hf + gm.hs));
    e.vs  = !((e.y >= gm.vd + gm.vf) && (e.y < gm.vd + gm.vf + gm.vs));
    return e;
  endfunction

  function automatic logic [31:0] exp_vec(int i);
    exp_t e;
    e = model(g[i], k[i]);
    return {e.pt, 11'(e.x), 11'(e.y), e.von, e.hs, e.vs, e.fs, erg[i]};
  endfunction

  function automatic logic [31:0] obs_vec(int i);
    return {ptk[i], px[i], py[i], von[i], hs[i], vs[i], fs[i], rgbo[i]};
  endfunction

  task automatic step(input bit rand_rgb);
    exp_t e;
    if (rand_rgb) rgb_in = 5'($urandom);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        k[i]   = 0;
        erg[i] = 5'd0;
      end else begin
        e      = model(g[i], k[i]);
        erg[i] = e.von ? rgb_in : 5'd0;
        k[i]   = k[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    repeat (10) step(1'b1);
    rst[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
    repeat (10) step(1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_vec(i) !== RESET_VEC)
        $display("FAIL reset dut%0d: got %h, required %h", i, obs_vec(i), RESET_VEC);
      else n_pass++;
    end
  endtask

  task automatic test_tick();
    int npt0 = 0, npt1 = 0, nth = 0;
    bit bad = 0;
    rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;
    for (int c = 0; c < 40 && !bad; c++) begin
      step(1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          $display("FAIL tick dut%0d k=%0d: got %h, required %h", i, k[i], obs_vec(i), exp_vec(i));
          bad = 1;
        end else n_pass++;
      end
      if (ptk[0] === 1'b1) begin
        npt0++;
        if (nth < 3) begin
          n_checks++;
          if (px[0] !== 11'(nth))
            $display("FAIL tick_px pulse%0d: got %0d, required %0d", nth, px[0], nth);
          else n_pass++;
          nth++;
        end
      end
      if (ptk[1] === 1'b1) npt1++;
    end
    n_checks++;
    if (npt0 != 10) $display("FAIL tick_count_div4: got %0d, required 10", npt0);
    else n_pass++;
    n_checks++;
    if (npt1 != 20) $display("FAIL tick_count_div2: got %0d, required 20", npt1);
    else n_pass++;
  endtask

  task automatic test_line();
    int prev_x, last_wrap = -1, nwrap = 0, hs_low = 0;
    logic prev_hs;
    bit bad = 0;
    prev_x = int'(px[0]); prev_hs = hs[0];
    for (int c = 0; c < 6600 && !bad; c++) begin
      step(1'b1);
      n_checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        $display("FAIL line k=%0d: got %h, required %h", k[0], obs_vec(0), exp_vec(0));
        bad = 1;
      end else n_pass++;
      if (px[0] == 11'd0 && prev_x == 799) begin
        nwrap++;
        if (last_wrap >= 0) begin
          n_checks++;
          if (k[0] - last_wrap != 3200)
            $display("FAIL line_period: got %0d clks, required 3200", k[0] - last_wrap);
          else n_pass++;
        end
        last_wrap = k[0];
      end
      if (prev_hs === 1'b1 && hs[0] === 1'b0) begin
        n_checks++;
        if (px[0] !== 11'd656) $display("FAIL hsync_fall: pixel_x %0d, required 656", px[0]);
        else n_pass++;
      end
      if (prev_hs === 1'b0 && hs[0] === 1'b1) begin
        n_checks++;
        if (px[0] !== 11'd752) $display("FAIL hsync_rise: pixel_x %0d, required 752", px[0]);
        else n_pass++;
      end
      if (c >= 100 && c < 3300 && hs[0] === 1'b0) hs_low++;
      prev_x = int'(px[0]); prev_hs = hs[0];
    end
    n_checks++;
    if (hs_low != 384) $display("FAIL hsync_width: got %0d clks, required 384", hs_low);
    else n_pass++;
    n_checks++;
    if (nwrap != 2) $display("FAIL line_wraps: got %0d, required 2", nwrap);
    else n_pass++;
  endtask

  task automatic test_blanking();
    logic prev_von[3];
    bit bad = 0;
    int i;
    rgb_in = 5'b11001;
    for (int j = 0; j < 3; j++) prev_von[j] = von[j];
    for (int c = 0; c < 3300 && !bad; c++) begin
      step(1'b0);
      for (int j = 0; j < 2; j++) begin
        i = j * 2;
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          $display("FAIL blank dut%0d k=%0d: got %h, required %h", i, k[i], obs_vec(i), exp_vec(i));
          bad = 1;
        end else n_pass++;
        n_checks++;
        if (rgbo[i] !== (prev_von[i] ? 5'b11001 : 5'd0)) begin
          $display("FAIL rgb_gate dut%0d k=%0d: got %b, required %b", i, k[i], rgbo[i],
                   prev_von[i] ? 5'b11001 : 5'd0);
          bad = 1;
        end else n_pass++;
      end
      if (prev_von[0] === 1'b1 && von[0] === 1'b0) begin
        n_checks++;
        if (px[0] !== 11'd640) $display("FAIL video_off_x: pixel_x %0d, required 640", px[0]);
        else n_pass++;
      end
      for (int j = 0; j < 3; j++) prev_von[j] = von[j];
    end
  endtask

  task automatic test_frame();
    int nfs = 0, last_fs = -1, vs_low = 0;
    bit bad = 0;
    do_reset(2);
    for (int c = 0; c < 2700 && !bad; c++) begin
      step(1'b1);
      n_checks++;
      if (obs_vec(2) !== exp_vec(2)) begin
        $display("FAIL frame k=%0d: got %h, required %h", k[2], obs_vec(2), exp_vec(2));
        bad = 1;
      end else n_pass++;
      if (fs[2] === 1'b1) begin
        nfs++;
        n_checks++;
        if ({px[2], py[2]} !== 22'd0)
          $display("FAIL fs_origin: got (%0d,%0d), required (0,0)", px[2], py[2]);
        else n_pass++;
        n_checks++;
        if (last_fs < 0 ? (k[2] != 1217) : (k[2] - last_fs != 1216))
          $display("FAIL frame_period: pulse at k=%0d, previous %0d, required 1217 then every 1216",
                   k[2], last_fs);
        else n_pass++;
        last_fs = k[2];
      end
      if (c < 1216 && vs[2] === 1'b0) vs_low++;
    end
    n_checks++;
    if (vs_low != 128) $display("FAIL vsync_width: got %0d clks, required 128", vs_low);
    else n_pass++;
    n_checks++;
    if (nfs != 2) $display("FAIL frame_count: got %0d, required 2", nfs);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit found = 0, bad = 0;
    for (int c = 0; c < 1300 && !found && !bad; c++) begin
      e = model(g[2], k[2]);
      if (e.x == 26 && e.y == 15) found = 1;
      else begin
        step(1'b1);
        n_checks++;
        if (obs_vec(2) !== exp_vec(2)) begin
          $display("FAIL mid_run k=%0d: got %h, required %h", k[2], obs_vec(2), exp_vec(2));
          bad = 1;
        end else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL mid_reach: position (26,15) not reached, got (%0d,%0d)", px[2], py[2]);
    end
    n_checks++;
    if ({hs[2], vs[2]} !== 2'b00)
      $display("FAIL mid_sync_low: got hsync/vsync %b, required 00", {hs[2], vs[2]});
    else n_pass++;
    rst[2] = 1'b1;
    step(1'b1);
    n_checks++;
    if (obs_vec(2) !== RESET_VEC)
      $display("FAIL mid_reset: got %h, required %h", obs_vec(2), RESET_VEC);
    else n_pass++;
    rst[2] = 1'b0;
    for (int c = 0; c < 30 && !bad; c++) begin
      step(1'b1);
      n_checks++;
      if (obs_vec(2) !== exp_vec(2)) begin
        $display("FAIL after_reset k=%0d: got %h, required %h", k[2], obs_vec(2), exp_vec(2));
        bad = 1;
      end else n_pass++;
    end
  endtask

  task automatic test_clkdiv2();
    int prev_x, last_wrap = -1, hs_low = 0, npt = 0;
    logic prev_hs;
    bit bad = 0;
    do_reset(1);
    prev_x = int'(px[1]); prev_hs = hs[1];
    for (int c = 0; c < 3400 && !bad; c++) begin
      step(1'b1);
      n_checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        $display("FAIL div2 k=%0d: got %h, required %h", k[1], obs_vec(1), exp_vec(1));
        bad = 1;
      end else n_pass++;
      if (px[1] == 11'd0 && prev_x == 799) begin
        if (last_wrap >= 0) begin
          n_checks++;
          if (k[1] - last_wrap != 1600)
            $display("FAIL div2_line_period: got %0d clks, required 1600", k[1] - last_wrap);
          else n_pass++;
        end
        last_wrap = k[1];
      end
      if (prev_hs === 1'b1 && hs[1] === 1'b0) begin
        n_checks++;
        if (px[1] !== 11'd656) $display("FAIL div2_hsync_fall: pixel_x %0d, required 656", px[1]);
        else n_pass++;
      end
      if (c < 1600 && hs[1] === 1'b0) hs_low++;
      if (c < 100 && ptk[1] === 1'b1) npt++;
      prev_x = int'(px[1]); prev_hs = hs[1];
    end
    n_checks++;
    if (hs_low != 192) $display("FAIL div2_hsync_width: got %0d clks, required 192", hs_low);
    else n_pass++;
    n_checks++;
    if (npt != 50) $display("FAIL div2_tick_count: got %0d, required 50", npt);
    else n_pass++;
    n_checks++;
    if (last_wrap != 3201) $display("FAIL div2_wrap_time: last wrap at k=%0d, required 3201", last_wrap);
    else n_pass++;
  endtask

  initial begin
    g[0] = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
    g[1] = '{d:2, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
    g[2] = '{d:2, hd:16,  hf:4,  hs:8,  hb:4,  vd:12,  vf:2,  vs:2, vb:3};
    for (int i = 0; i < 3; i++) begin
      k[i]   = 0;
      erg[i] = 5'd0;
      rst[i] = 1'b1;
    end
    rgb_in = 5'd0;
    test_reset();
    test_tick();
    test_line();
    test_blanking();
    test_frame();
    test_mid_reset();
    test_clkdiv2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
